// File: rtl/clk_div_monitor.sv
// Receive-side checker for a divided clock synchronous to clk: measures period and
// high time in clk cycles, and reports lock, mismatch and stuck against the expected ratio.
module clk_div_monitor #(
    parameter int unsigned DIV      = 3,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned TIMEOUT  = 64,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             div_in,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             meas_valid,
    output logic             locked,
    output logic             err,
    output logic             stuck
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_MEAS   = 2'd2;
    localparam logic [1:0] ST_LOCKED = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] DIV_C    = CNT_W'(DIV);
    localparam logic [CNT_W-1:0] TMO_C    = CNT_W'(TIMEOUT);
    localparam logic [3:0]       LOCK_C   = 4'(LOCK_CNT);

    logic [1:0]       state_q,      state_d;
    logic             d_q;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic [CNT_W-1:0] hcnt_q,       hcnt_d;
    logic [3:0]       match_q,      match_d;
    logic [CNT_W-1:0] period_q,     period_d;
    logic [CNT_W-1:0] high_q,       high_d;
    logic             meas_valid_q, meas_valid_d;
    logic             locked_q,     locked_d;
    logic             err_q,        err_d;
    logic             stuck_q,      stuck_d;

    logic             rise_s;
    logic             timeout_s;
    logic [3:0]       match_inc_s;

    // Saturating add of a single bit to a counter.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic b);
        logic [CNT_W-1:0] r;
        if (b && (a == CNT_MAX)) begin
            r = a;
        end else begin
            r = a + {{(CNT_W-1){1'b0}}, b};
        end
        return r;
    endfunction

    // Edge detect, timeout detect and saturating match increment.
    always_comb begin
        rise_s    = div_in & ~d_q;
        timeout_s = (cnt_q == TMO_C) & ~rise_s;
        if (match_q == LOCK_C) begin
            match_inc_s = match_q;
        end else begin
            match_inc_s = match_q + 4'd1;
        end
    end

    // Next-state logic: rise beats timeout, en low discards any measurement in flight.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hcnt_d       = hcnt_q;
        match_d      = match_q;
        period_d     = period_q;
        high_d       = high_q;
        meas_valid_d = 1'b0;
        err_d        = 1'b0;
        locked_d     = locked_q;
        stuck_d      = stuck_q;

        if (!en) begin
            state_d  = ST_IDLE;
            cnt_d    = CNT_ZERO;
            hcnt_d   = CNT_ZERO;
            match_d  = 4'd0;
            locked_d = 1'b0;
            stuck_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d    = CNT_ZERO;
                    hcnt_d   = CNT_ZERO;
                    match_d  = 4'd0;
                    locked_d = 1'b0;
                    stuck_d  = 1'b0;
                    state_d  = ST_WAIT;
                end
                ST_WAIT, ST_MEAS, ST_LOCKED: begin
                    if (rise_s) begin
                        cnt_d   = CNT_ONE;
                        hcnt_d  = CNT_ONE;
                        stuck_d = 1'b0;
                        if (state_q == ST_WAIT) begin
                            state_d = ST_MEAS;
                        end else begin
                            period_d     = cnt_q;
                            high_d       = hcnt_q;
                            meas_valid_d = 1'b1;
                            if (cnt_q == DIV_C) begin
                                match_d = match_inc_s;
                                if (match_inc_s == LOCK_C) begin
                                    locked_d = 1'b1;
                                    state_d  = ST_LOCKED;
                                end else begin
                                    state_d  = ST_MEAS;
                                end
                            end else begin
                                err_d    = 1'b1;
                                match_d  = 4'd0;
                                locked_d = 1'b0;
                                state_d  = ST_MEAS;
                            end
                        end
                    end else begin
                        cnt_d  = sat_add(cnt_q, 1'b1);
                        hcnt_d = sat_add(hcnt_q, div_in);
                        if (timeout_s) begin
                            stuck_d  = 1'b1;
                            locked_d = 1'b0;
                            match_d  = 4'd0;
                            state_d  = ST_WAIT;
                        end else begin
                            state_d  = state_q;
                        end
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    cnt_d    = CNT_ZERO;
                    hcnt_d   = CNT_ZERO;
                    match_d  = 4'd0;
                    locked_d = 1'b0;
                    stuck_d  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            d_q          <= 1'b0;
            cnt_q        <= CNT_ZERO;
            hcnt_q       <= CNT_ZERO;
            match_q      <= 4'd0;
            period_q     <= CNT_ZERO;
            high_q       <= CNT_ZERO;
            meas_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            err_q        <= 1'b0;
            stuck_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            d_q          <= div_in;
            cnt_q        <= cnt_d;
            hcnt_q       <= hcnt_d;
            match_q      <= match_d;
            period_q     <= period_d;
            high_q       <= high_d;
            meas_valid_q <= meas_valid_d;
            locked_q     <= locked_d;
            err_q        <= err_d;
            stuck_q      <= stuck_d;
        end
    end

    assign period_out = period_q;
    assign high_out   = high_q;
    assign meas_valid = meas_valid_q;
    assign locked     = locked_q;
    assign err        = err_q;
    assign stuck      = stuck_q;

endmodule
